// File: rtl/assert_window_monitor.sv
// assert_window_monitor: checks the consequent side of a bounded temporal rule
// (antecedent edge |-> ##[cfg_min:cfg_max] consequent edge) on the in/out buses
// of an FSM under test. Each antecedent edge starts an independent attempt in a
// shift-register age tracker. Attempts pass on their earliest in-window
// consequent edge and fail when they reach cfg_max without one.
// Optional build macro: AWM_FIRST_FAIL_EN adds a free-running cycle counter and
// captures its value at the first failure into first_fail_cyc.
module assert_window_monitor #(
  parameter int unsigned W       = 7,
  parameter int unsigned MAX_DLY = 127,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     fsm_in,
  input  logic [W-1:0]     fsm_out,
  input  logic [3:0]       cfg_ant_sel,
  input  logic             cfg_ant_rise,
  input  logic [3:0]       cfg_con_sel,
  input  logic             cfg_con_rise,
  input  logic [6:0]       cfg_min,
  input  logic [6:0]       cfg_max,
  input  logic             cfg_load,
  input  logic             enable,
  output logic             armed,
  output logic             cfg_err,
  output logic             pending,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [15:0]      first_fail_cyc
);

  localparam int unsigned PC_W = $clog2(MAX_DLY + 2);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t state_q, state_d;

  // latched configuration
  logic [3:0] ant_sel_q, con_sel_q;
  logic       ant_rise_q, con_rise_q;
  logic [6:0] min_q, max_q;

  // edge detection
  logic [2*W-1:0] cur_bus, prev_bus;
  logic           prev_valid;
  logic           ant_cur, ant_prv, con_cur, con_prv;
  logic           ant_edge, con_edge;

  // attempt tracker: age_q[k] set means an attempt of age k+1 exists next edge
  logic [MAX_DLY-1:0] age_q, age_d;
  logic [MAX_DLY:0]   cur_age, pass_vec, fail_vec;
  logic [PC_W-1:0]    pass_n, fail_n;

  logic load_ok, run;

  assign cur_bus  = {fsm_out, fsm_in};
  assign ant_cur  = cur_bus[ant_sel_q];
  assign ant_prv  = prev_bus[ant_sel_q];
  assign con_cur  = cur_bus[con_sel_q];
  assign con_prv  = prev_bus[con_sel_q];
  assign ant_edge = prev_valid && (ant_rise_q ? (ant_cur && !ant_prv) : (!ant_cur && ant_prv));
  assign con_edge = prev_valid && (con_rise_q ? (con_cur && !con_prv) : (!con_cur && con_prv));

  assign load_ok = (cfg_min <= cfg_max) && (32'(cfg_max) <= MAX_DLY) &&
                   (cfg_ant_sel <= 4'd13) && (cfg_con_sel <= 4'd13);
  assign run     = (state_q == ARMED) && enable;
  assign armed   = (state_q == ARMED);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state: arm only on a clean config with no load in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !cfg_load && !cfg_err) state_d = ARMED;
      ARMED:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // age every attempt, resolve passes in the window and failures at max
  always_comb begin
    cur_age  = {age_q, ant_edge};
    pass_vec = '0;
    fail_vec = '0;
    age_d    = '0;
    pass_n   = '0;
    fail_n   = '0;
    for (int unsigned k = 0; k <= MAX_DLY; k++) begin
      if (cur_age[k] && con_edge && (k >= 32'(min_q)) && (k <= 32'(max_q)))
        pass_vec[k] = 1'b1;
      else if (cur_age[k] && (k == 32'(max_q)))
        fail_vec[k] = 1'b1;
      pass_n = pass_n + PC_W'(pass_vec[k]);
      fail_n = fail_n + PC_W'(fail_vec[k]);
    end
    for (int unsigned k = 0; k < MAX_DLY; k++)
      age_d[k] = cur_age[k] && !pass_vec[k] && (k < 32'(max_q));
  end

  // config latch, edge history, tracker and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ant_sel_q  <= '0;
      con_sel_q  <= '0;
      ant_rise_q <= 1'b1;
      con_rise_q <= 1'b1;
      min_q      <= '0;
      max_q      <= '0;
      cfg_err    <= 1'b0;
      prev_bus   <= '0;
      prev_valid <= 1'b0;
      age_q      <= '0;
      pending    <= 1'b0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      prev_bus   <= cur_bus;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      if (state_q == IDLE) begin
        prev_valid <= 1'b0;
        age_q      <= '0;
        pending    <= 1'b0;
        if (cfg_load) begin
          if (load_ok) begin
            ant_sel_q  <= cfg_ant_sel;
            con_sel_q  <= cfg_con_sel;
            ant_rise_q <= cfg_ant_rise;
            con_rise_q <= cfg_con_rise;
            min_q      <= cfg_min;
            max_q      <= cfg_max;
            cfg_err    <= 1'b0;
          end else begin
            cfg_err    <= 1'b1;
          end
        end
      end else if (!run) begin
        prev_valid <= 1'b0;
        age_q      <= '0;
        pending    <= 1'b0;
      end else begin
        prev_valid <= 1'b1;
        age_q      <= age_d;
        pending    <= |age_d;
        pass_pulse <= |pass_vec;
        fail_pulse <= |fail_vec;
        pass_cnt   <= sat_add(pass_cnt, pass_n);
        fail_cnt   <= sat_add(fail_cnt, fail_n);
      end
    end
  end

`ifdef AWM_FIRST_FAIL_EN
  logic [15:0] cyc_q, ffc_q;
  logic        ff_seen;

  // free-running cycle count, captured once at the first failing edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      ffc_q   <= '0;
      ff_seen <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 16'd1;
      if (run && (|fail_vec) && !ff_seen) begin
        ffc_q   <= cyc_q;
        ff_seen <= 1'b1;
      end
    end
  end

  assign first_fail_cyc = ffc_q;
`else
  assign first_fail_cyc = '0;
`endif

endmodule

// File: tb/tb_assert_window_monitor.sv
// Bench for assert_window_monitor: table vectors, directed window/overlap/abort
// sequences, then random traffic checked every cycle against a timestamp-queue
// model of the temporal rule.
module tb_assert_window_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  fsm_in = '0, fsm_out = '0;
  logic [3:0]  cfg_ant_sel = '0, cfg_con_sel = '0;
  logic        cfg_ant_rise = 1'b1, cfg_con_rise = 1'b1;
  logic [6:0]  cfg_min = '0, cfg_max = '0;
  logic        cfg_load = 1'b0, enable = 1'b0;
  logic        armed, cfg_err, pending, pass_pulse, fail_pulse;
  logic [15:0] pass_cnt, fail_cnt, first_fail_cyc;

  assert_window_monitor #(.W(7), .MAX_DLY(127), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fsm_in(fsm_in), .fsm_out(fsm_out),
    .cfg_ant_sel(cfg_ant_sel), .cfg_ant_rise(cfg_ant_rise),
    .cfg_con_sel(cfg_con_sel), .cfg_con_rise(cfg_con_rise),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_load(cfg_load), .enable(enable),
    .armed(armed), .cfg_err(cfg_err), .pending(pending),
    .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_cyc(first_fail_cyc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state: attempts are kept as antecedent timestamps
  bit         m_armed, m_err, m_pv, m_pp, m_fp, m_seen;
  int         m_as, m_ar, m_cs, m_cr, m_min, m_max;
  logic [6:0] m_pin, m_pout;
  int         m_t, m_pc, m_fc, m_cyc, m_ffc;
  int         starts[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit pick(input int sel, input logic [6:0] i, input logic [6:0] o);
    return (sel < 7) ? i[sel] : o[sel-7];
  endfunction

  task automatic model_step();
    int  np, nf, d;
    int  keep[$];
    bit  a_now, c_now, a_e, c_e;
    if (!rst_n) begin
      m_armed = 0; m_err = 0; m_pv = 0; m_pp = 0; m_fp = 0; m_seen = 0;
      m_as = 0; m_ar = 1; m_cs = 0; m_cr = 1; m_min = 0; m_max = 0;
      m_pc = 0; m_fc = 0; m_cyc = 0; m_ffc = 0;
      starts.delete();
      m_pin = fsm_in; m_pout = fsm_out; m_t++;
      return;
    end
    np = 0; nf = 0; m_pp = 0; m_fp = 0;
    if (!m_armed) begin
      if (cfg_load) begin
        if (cfg_min > cfg_max || int'(cfg_max) > 127 || cfg_ant_sel > 13 || cfg_con_sel > 13)
          m_err = 1;
        else begin
          m_as = cfg_ant_sel; m_ar = cfg_ant_rise; m_cs = cfg_con_sel; m_cr = cfg_con_rise;
          m_min = cfg_min; m_max = cfg_max; m_err = 0;
        end
      end else if (enable && !m_err) m_armed = 1;
      m_pv = 0; starts.delete();
    end else if (!enable) begin
      m_armed = 0; m_pv = 0; starts.delete();
    end else begin
      a_now = pick(m_as, fsm_in, fsm_out);
      c_now = pick(m_cs, fsm_in, fsm_out);
      a_e = m_pv && (a_now != pick(m_as, m_pin, m_pout)) && (a_now == m_ar[0]);
      c_e = m_pv && (c_now != pick(m_cs, m_pin, m_pout)) && (c_now == m_cr[0]);
      if (a_e) starts.push_back(m_t);
      foreach (starts[i]) begin
        d = m_t - starts[i];
        if (c_e && d >= m_min && d <= m_max) np++;
        else if (d == m_max) nf++;
        else keep.push_back(starts[i]);
      end
      starts = keep;
      m_pp = (np > 0); m_fp = (nf > 0);
      m_pc = (m_pc + np > 65535) ? 65535 : m_pc + np;
      m_fc = (m_fc + nf > 65535) ? 65535 : m_fc + nf;
      if (nf > 0 && !m_seen) begin m_seen = 1; m_ffc = m_cyc; end
      m_pv = 1;
    end
    m_pin = fsm_in; m_pout = fsm_out; m_t++;
    m_cyc = (m_cyc + 1) % 65536;
  endtask

  task automatic check_model();
    int exp_ffc;
`ifdef AWM_FIRST_FAIL_EN
    exp_ffc = m_ffc;
`else
    exp_ffc = 0;
`endif
    chk("m.armed",   32'(armed),      32'(m_armed));
    chk("m.cfg_err", 32'(cfg_err),    32'(m_err));
    chk("m.pending", 32'(pending),    32'(starts.size() != 0));
    chk("m.pass",    32'(pass_pulse), 32'(m_pp));
    chk("m.fail",    32'(fail_pulse), 32'(m_fp));
    chk("m.pcnt",    32'(pass_cnt),   32'(m_pc));
    chk("m.fcnt",    32'(fail_cnt),   32'(m_fc));
    chk("m.ffc",     32'(first_fail_cyc), 32'(exp_ffc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst.armed", 32'(armed), 0);
    chk("rst.err",   32'(cfg_err), 0);
    chk("rst.pend",  32'(pending), 0);
    chk("rst.pass",  32'(pass_pulse), 0);
    chk("rst.fail",  32'(fail_pulse), 0);
    chk("rst.pcnt",  32'(pass_cnt), 0);
    chk("rst.fcnt",  32'(fail_cnt), 0);
    chk("rst.ffc",   32'(first_fail_cyc), 0);
    rst_n = 1'b1;
  endtask

  task automatic setup(input int as_, input int ar, input int cs, input int cr,
                       input int mn, input int mx);
    enable = 1'b0; cfg_load = 1'b0;
    tick();
    cfg_ant_sel = 4'(as_); cfg_ant_rise = ar[0];
    cfg_con_sel = 4'(cs);  cfg_con_rise = cr[0];
    cfg_min = 7'(mn); cfg_max = 7'(mx); cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("setup.err", 32'(cfg_err), 0);
    enable = 1'b1;
    tick();
    chk("setup.armed", 32'(armed), 1);
    tick();
  endtask

  // antecedent = fell in[0], consequent = fell out[2], window [6:51]
  task automatic attempt(input int dly, input int exp_pc, input int exp_fc);
    bit hit;
    hit = (dly >= 6 && dly <= 51);
    fsm_in[0] = 1'b1; fsm_out[2] = 1'b1;
    tick(); tick();
    for (int k = 0; k <= 53; k++) begin
      if (k == 0)   fsm_in[0]  = 1'b0;
      if (k == dly) fsm_out[2] = 1'b0;
      tick();
      chk($sformatf("d%0d.pass@%0d", dly, k), 32'(pass_pulse), 32'(hit && k == dly));
      chk($sformatf("d%0d.fail@%0d", dly, k), 32'(fail_pulse), 32'(!hit && k == 51));
    end
    chk($sformatf("d%0d.pcnt", dly), 32'(pass_cnt), 32'(exp_pc));
    chk($sformatf("d%0d.fcnt", dly), 32'(fail_cnt), 32'(exp_fc));
  endtask

  typedef struct {
    logic       en, ld;
    logic [6:0] mn, mx;
    logic [3:0] as_, cs;
    logic [6:0] fi, fo;
    logic       e_arm, e_err, e_pend, e_pp, e_fp;
  } vec_t;

  function automatic vec_t mk(input int en, input int ld, input int mn, input int mx,
                              input int as_, input int cs, input int fi, input int fo,
                              input int ea, input int ee, input int ep, input int epp,
                              input int efp);
    vec_t v;
    v.en = en[0]; v.ld = ld[0]; v.mn = mn[6:0]; v.mx = mx[6:0];
    v.as_ = as_[3:0]; v.cs = cs[3:0]; v.fi = fi[6:0]; v.fo = fo[6:0];
    v.e_arm = ea[0]; v.e_err = ee[0]; v.e_pend = ep[0]; v.e_pp = epp[0]; v.e_fp = efp[0];
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    // ant = rise in[3] (sel 3), con = rise out[6] (sel 13), window [0:2]
    tbl[0]  = mk(0,1,5,2, 3,13, 0,'h00, 0,1,0,0,0);  // min > max rejected
    tbl[1]  = mk(1,0,5,2, 3,13, 0,'h00, 0,1,0,0,0);  // error blocks arming
    tbl[2]  = mk(0,1,0,2,14,13, 0,'h00, 0,1,0,0,0);  // illegal select rejected
    tbl[3]  = mk(0,1,0,2, 3,13, 0,'h00, 0,0,0,0,0);  // good load clears error
    tbl[4]  = mk(1,0,0,2, 3,13, 0,'h00, 1,0,0,0,0);  // arm
    tbl[5]  = mk(1,0,0,2, 3,13, 8,'h00, 1,0,0,0,0);  // first sample: no edge
    tbl[6]  = mk(1,0,0,2, 3,13, 0,'h00, 1,0,0,0,0);  // falling: wrong polarity
    tbl[7]  = mk(1,0,0,2, 3,13, 8,'h00, 1,0,1,0,0);  // antecedent
    tbl[8]  = mk(1,0,0,2, 3,13, 8,'h00, 1,0,1,0,0);
    tbl[9]  = mk(1,0,0,2, 3,13, 8,'h40, 1,0,0,1,0);  // consequent at age 2
    tbl[10] = mk(1,0,0,2, 3,13, 8,'h40, 1,0,0,0,0);
    tbl[11] = mk(1,0,0,2, 3,13, 0,'h40, 1,0,0,0,0);
    tbl[12] = mk(1,0,0,2, 3,13, 8,'h40, 1,0,1,0,0);  // antecedent
    tbl[13] = mk(1,0,0,2, 3,13, 8,'h40, 1,0,1,0,0);
    tbl[14] = mk(1,0,0,2, 3,13, 8,'h40, 1,0,0,0,1);  // expires at max
    tbl[15] = mk(0,0,0,2, 3,13, 8,'h40, 0,0,0,0,0);  // disarm

    do_reset();
    cfg_ant_rise = 1'b1; cfg_con_rise = 1'b1;
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en; cfg_load = tbl[i].ld;
      cfg_min = tbl[i].mn; cfg_max = tbl[i].mx;
      cfg_ant_sel = tbl[i].as_; cfg_con_sel = tbl[i].cs;
      fsm_in = tbl[i].fi; fsm_out = tbl[i].fo;
      tick();
      chk($sformatf("tbl%0d.armed", i), 32'(armed),      32'(tbl[i].e_arm));
      chk($sformatf("tbl%0d.err", i),   32'(cfg_err),    32'(tbl[i].e_err));
      chk($sformatf("tbl%0d.pend", i),  32'(pending),    32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d.pass", i),  32'(pass_pulse), 32'(tbl[i].e_pp));
      chk($sformatf("tbl%0d.fail", i),  32'(fail_pulse), 32'(tbl[i].e_fp));
    end
    cfg_load = 1'b0;

    // window boundaries
    do_reset();
    fsm_in = '0; fsm_out = '0;
    setup(0, 0, 9, 0, 6, 51);
    attempt(20, 1, 0);
    attempt(5,  1, 1);
    attempt(51, 2, 1);
    attempt(52, 2, 2);

    // overlap: ant = rise in[1], con = rise out[0], window [0:4]
    fsm_in = '0; fsm_out = '0;
    setup(1, 1, 7, 1, 0, 4);
    fsm_in[1] = 1'b1; tick();
    chk("ovl.pend0", 32'(pending), 1);
    fsm_in[1] = 1'b0; tick();
    fsm_in[1] = 1'b1; tick();
    fsm_out[0] = 1'b1; tick();
    chk("ovl.pass3", 32'(pass_pulse), 1);
    chk("ovl.pcnt3", 32'(pass_cnt), 4);
    chk("ovl.pend3", 32'(pending), 0);
    fsm_in[1] = 1'b0; fsm_out[0] = 1'b0; tick();
    chk("ovl.pass4", 32'(pass_pulse), 0);
    tick(); tick(); tick();
    fsm_in[1] = 1'b1; fsm_out[0] = 1'b1; tick();
    chk("ovl.pass8", 32'(pass_pulse), 1);
    chk("ovl.pcnt8", 32'(pass_cnt), 5);
    chk("ovl.fcnt8", 32'(fail_cnt), 2);

    // abort: two pending attempts dropped by disarm
    fsm_in[1] = 1'b0; tick();
    fsm_in[1] = 1'b1; tick();
    fsm_in[1] = 1'b0; tick();
    fsm_in[1] = 1'b1; tick();
    chk("abt.pend", 32'(pending), 1);
    enable = 1'b0; tick();
    chk("abt.pend_off", 32'(pending), 0);
    chk("abt.armed",    32'(armed), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("abt.pcnt", 32'(pass_cnt), 5);
    chk("abt.fcnt", 32'(fail_cnt), 2);

    // reset mid-window
    setup(1, 1, 7, 1, 0, 4);
    fsm_in[1] = 1'b0; tick();
    fsm_in[1] = 1'b1; tick();
    chk("rmw.pend", 32'(pending), 1);
    do_reset();

    // random traffic against the model
    enable = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      cfg_load     = ($urandom_range(0, 3) == 0);
      cfg_ant_sel  = 4'($urandom_range(0, 15));
      cfg_con_sel  = 4'($urandom_range(0, 15));
      cfg_ant_rise = 1'($urandom_range(0, 1));
      cfg_con_rise = 1'($urandom_range(0, 1));
      cfg_min      = 7'($urandom_range(0, 12));
      cfg_max      = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                 : 7'($urandom_range(0, 12));
      fsm_in  = fsm_in  ^ 7'($urandom & $urandom);
      fsm_out = fsm_out ^ 7'($urandom & $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
